// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/write-back and drives all datapath controls.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADDR = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_REXEC   = 4'd6;
    localparam logic [3:0] S_RWB     = 4'd7;
    localparam logic [3:0] S_BNE     = 4'd8;
    localparam logic [3:0] S_IEXEC   = 4'd9;
    localparam logic [3:0] S_IWB     = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [5:0] r_op_q;
    logic       r_illegal;
    logic       w_legal;

    always_comb begin
        w_legal = 1'b0;
        unique case (1'b1)
            opcode == OP_R,    opcode == OP_J,
            opcode == OP_BNE,  opcode == OP_ADDI,
            opcode == OP_ANDI, opcode == OP_LUI,
            opcode == OP_LW,   opcode == OP_SW: w_legal = 1'b1;
            default:                            w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_op_q    <= 6'h00;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= (r_state == S_DECODE) && !w_legal;
            if (r_state == S_DECODE)
                r_op_q <= opcode;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:             w_next = S_MEMADDR;
                    OP_R:                     w_next = S_REXEC;
                    OP_BNE:                   w_next = S_BNE;
                    OP_ADDI, OP_ANDI, OP_LUI: w_next = S_IEXEC;
                    OP_J:                     w_next = S_JUMP;
                    default:                  w_next = S_FETCH;
                endcase
            end
            S_MEMADDR: w_next = (r_op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_REXEC:   w_next = S_RWB;
            S_RWB:     w_next = S_FETCH;
            S_BNE:     w_next = S_FETCH;
            S_IEXEC:   w_next = S_IWB;
            S_IWB:     w_next = S_FETCH;
            S_JUMP:    w_next = S_FETCH;
            default:   w_next = S_FETCH;
        endcase
    end

    // Reset gates the FETCH handshake so an abandoned instruction issues no strobes.
    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_source  = 2'b00;
        alu_op     = 3'b000;
        instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 3'b010;
                ir_write  = mem_ready & rst_n;
                pc_en     = mem_ready & rst_n;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                alu_op     = 3'b010;
                instr_done = !w_legal;
            end
            S_MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 3'b010;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_REXEC: alu_src_a = 1'b1;
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BNE: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b001;
                pc_source  = 2'b01;
                pc_en      = ~zero;
                instr_done = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (r_op_q)
                    OP_ANDI: alu_op = 3'b100;
                    OP_LUI:  alu_op = 3'b101;
                    default: alu_op = 3'b011;
                endcase
            end
            S_IWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_source  = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal = r_illegal;
    assign state   = r_state;
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states. Drives every datapath enable and mux select, including the 3-bit `alu_op` code consumed by the ALU control decoder. The block sits between the instruction register opcode field and the datapath. It also owns the PC-write decision for jumps and BNE.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26].
- `zero`  in  1  ALU zero flag, valid in the BNE state.
- `mem_ready`  in  1  memory handshake; completes the current memory access.
- `pc_en`  out  1  PC write enable (unconditional or BNE-taken).
- `iord`  out  1  0: memory address from PC; 1: address from ALUOut.
- `mem_read`, `mem_write`  out  1  memory strobes.
- `ir_write`  out  1  IR load.
- `mem_to_reg`, `reg_dst`, `reg_write`  out  1  register-file controls.
- `alu_src_a`  out  1  0: PC; 1: A.
- `alu_src_b`  out  2  00: B; 01: 4; 10: sign-extended immediate; 11: immediate<<2.
- `pc_source`  out  2  00: ALU; 01: ALUOut; 10: jump target.
- `alu_op`  out  3  000 R-type, 001 BNE (sub), 010 add, 011 ADDI, 100 ANDI, 101 LUI.
- `instr_done`  out  1  high in the last cycle of each instruction.
- `illegal`  out  1  registered 1-cycle pulse on an undefined opcode.
- `state`  out  4  current state encoding, for debug.

## Operation
- State register is 4-bit. Outputs are decoded combinationally from state, plus `mem_ready`/`zero` where noted. Any output not listed for a state is 0.
- Opcodes: R=0x00, J=0x02, BNE=0x05, ADDI=0x08, ANDI=0x0C, LUI=0x0F, LW=0x23, SW=0x2B.
- FETCH (0):
  - Outputs: `mem_read`=1, `iord`=0, `alu_src_b`=01, `alu_op`=010, `pc_source`=00, `ir_write`=`pc_en`=`mem_ready`.
  - Stays in FETCH until `mem_ready`=1, then goes to DECODE.
- DECODE (1):
  - Outputs: `alu_src_b`=11, `alu_op`=010 (branch target into ALUOut).
  - Latches `opcode` into internal `op_q`. Later states use `op_q` only.
  - Next state: LW/SW→MEMADDR, R→REXEC, BNE→BNE, ADDI/ANDI/LUI→IEXEC, J→JUMP.
  - Any other opcode→FETCH. `illegal` is then high for the next cycle; `instr_done`=1 in DECODE.
- MEMADDR (2): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=010. Next is MEMRD for LW, MEMWR for SW.
- MEMRD (3): `mem_read`=1, `iord`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB (4): `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1. Next is FETCH.
- MEMWR (5): `mem_write`=1, `iord`=1. Holds until `mem_ready`, then goes to FETCH; `instr_done`=`mem_ready`.
- REXEC (6): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=000. Next is RWB.
- RWB (7): `reg_write`=1, `reg_dst`=1, `instr_done`=1. Next is FETCH.
- BNE (8):
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=001, `pc_source`=01, `pc_en`=~`zero`, `instr_done`=1.
  - Next is FETCH.
- IEXEC (9):
  - Outputs: `alu_src_a`=1, `alu_src_b`=10.
  - `alu_op`=011 for ADDI, 100 for ANDI, 101 for LUI (from `op_q`).
  - Next is IWB.
- IWB (10): `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `instr_done`=1. Next is FETCH.
- JUMP (11): `pc_source`=10, `pc_en`=1, `instr_done`=1. Next is FETCH.
- Encodings 12–15 are unreachable. If entered, go to FETCH with all outputs 0.

## Timing
- Reset (`rst_n`=0) takes effect immediately, without waiting for `clk`:
  - state=FETCH, `op_q`=0, `illegal`=0.
  - Outputs show FETCH decode gated by `mem_ready`: `mem_read`=1, `alu_src_b`=01, `alu_op`=010, all others 0.
- Reset mid-instruction abandons the instruction with no further strobes. The first edge after release evaluates FETCH.
- Cycles per instruction with `mem_ready` tied high:

  | Instruction | Cycles |
  |---|---|
  | J, BNE | 3 |
  | R, SW, ADDI, ANDI, LUI | 4 |
  | LW | 5 |
  | Illegal | 2 |

- Each `mem_ready`=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. No strobe is dropped while stalled.
- `pc_en` asserts at most once in FETCH and at most once in BNE/JUMP per instruction.
- `opcode` changes after DECODE have no effect.

## Test plan
- Reset mid-LW (in MEMRD): assert `rst_n`=0 asynchronously → `state`=0, `mem_read`=1, `iord`=0, `reg_write`=0 before the next edge.
- R-type (`opcode`=0x00), `mem_ready`=1 → states 0,1,6,7; `alu_op`=000 in state 6; `reg_write`=`reg_dst`=1 in state 7; `instr_done` high in state 7 only.
- LW 0x23 with `mem_ready` low for 2 cycles in both FETCH and MEMRD → 9 cycles total; `ir_write` and `pc_en` pulse only on the ready cycle; `mem_to_reg`=1 in MEMWB.
- BNE 0x05: with `zero`=0 → `pc_en`=1 with `pc_source`=01 in state 8. With `zero`=1 → `pc_en`=0. Both take 3 cycles.
- ADDI/ANDI/LUI (0x08/0x0C/0x0F) → `alu_op` 011/100/101 in IEXEC. Change `opcode` to 0x2B during IEXEC → `alu_op` unchanged.
- Illegal opcode 0x3F → DECODE→FETCH; `illegal`=1 for exactly one cycle; no `reg_write`, `mem_write` or extra `pc_en`.
